// File: rtl/control_pkg.sv
// Shared definitions for the multicycle control unit: FSM states,
// opcode values, instruction-class indices and datapath mux encodings.
package control_pkg;

   localparam int OPCODE_WIDTH = 6;
   localparam int ALU_WIDTH = 5;
   localparam logic [ALU_WIDTH-1:0] ALU_ADD_CODE = 5'b11111;

   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      MEMADR,
      MEMRD,
      MEMWB,
      MEMWR,
      EXEC_R,
      WB_R,
      EXEC_I,
      WB_I,
      BRANCH,
      JAL,
      JR
   } state_t;

   localparam logic [OPCODE_WIDTH-1:0] OP_ANDR = 6'b100000;
   localparam logic [OPCODE_WIDTH-1:0] OP_NORR = 6'b100110;
   localparam logic [OPCODE_WIDTH-1:0] OP_NOTR = 6'b000100;
   localparam logic [OPCODE_WIDTH-1:0] OP_ROLV = 6'b000000;
   localparam logic [OPCODE_WIDTH-1:0] OP_RORV = 6'b000010;
   localparam logic [OPCODE_WIDTH-1:0] OP_NORI = 6'b001110;
   localparam logic [OPCODE_WIDTH-1:0] OP_LW   = 6'b100011;
   localparam logic [OPCODE_WIDTH-1:0] OP_SW   = 6'b101011;
   localparam logic [OPCODE_WIDTH-1:0] OP_BLEU = 6'b010000;
   localparam logic [OPCODE_WIDTH-1:0] OP_JAL  = 6'b000011;
   localparam logic [OPCODE_WIDTH-1:0] OP_JR   = 6'b001000;

   // Bit positions inside the one-hot instruction class vector
   localparam int CLS_R    = 0;
   localparam int CLS_NORI = 1;
   localparam int CLS_LW   = 2;
   localparam int CLS_SW   = 3;
   localparam int CLS_BLEU = 4;
   localparam int CLS_JAL  = 5;
   localparam int CLS_JR   = 6;
   localparam int CLS_N    = 7;

   localparam logic [1:0] SRCB_REGB  = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] PCSRC_REGA   = 2'b11;

   localparam logic [1:0] REGDST_RT  = 2'b00;
   localparam logic [1:0] REGDST_RD  = 2'b01;
   localparam logic [1:0] REGDST_R31 = 2'b10;

   localparam logic [1:0] MEMTOREG_ALUOUT = 2'b00;
   localparam logic [1:0] MEMTOREG_MDR    = 2'b01;
   localparam logic [1:0] MEMTOREG_PC     = 2'b10;

endpackage

// File: rtl/control_opclass.sv
// Opcode classifier: turns the instruction opcode into a one-hot class
// vector so the FSM dispatches on a class rather than on raw opcodes.
module control_opclass
   import control_pkg::*;
(
   input  logic [OPCODE_WIDTH-1:0] opcode,
   output logic [CLS_N-1:0]        opclass,
   output logic                    valid
);

   // Unknown opcodes leave every class bit clear and drop valid
   always_comb begin
      opclass = '0;
      valid = 1'b1;
      case (opcode)
         OP_ANDR, OP_NORR, OP_NOTR, OP_ROLV, OP_RORV: opclass[CLS_R] = 1'b1;
         OP_NORI: opclass[CLS_NORI] = 1'b1;
         OP_LW:   opclass[CLS_LW] = 1'b1;
         OP_SW:   opclass[CLS_SW] = 1'b1;
         OP_BLEU: opclass[CLS_BLEU] = 1'b1;
         OP_JAL:  opclass[CLS_JAL] = 1'b1;
         OP_JR:   opclass[CLS_JR] = 1'b1;
         default: valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: steps each instruction through fetch, decode
// and its class-specific execute/memory/writeback states, stalling on
// mem_ready during instruction fetch, load read and store write.
module multicycle_control
   import control_pkg::*;
#(
   parameter int OP_W = OPCODE_WIDTH,
   parameter int ALU_W = ALU_WIDTH,
   parameter logic [ALU_W-1:0] ALU_ADD = ALU_ADD_CODE
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic [OP_W-1:0]  opcode,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             IorD,
   output logic             IRWrite,
   output logic             MemWrite,
   output logic             RegWrite,
   output logic [1:0]       RegDst,
   output logic [1:0]       MemToReg,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [ALU_W-1:0] ALUControl,
   output logic [1:0]       PCSrc,
   output logic             Branch,
   output logic             instr_done,
   output logic             illegal_op
);

   state_t state;
   logic [CLS_N-1:0] opclass;
   logic op_valid;

   control_opclass u_opclass (
      .opcode  (opcode),
      .opclass (opclass),
      .valid   (op_valid)
   );

   // State register with next-state selection; reset abandons any instruction
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
      end else begin
         case (state)
            FETCH:  if (mem_ready) state <= DECODE;
            DECODE: begin
               if (!op_valid)               state <= FETCH;
               else if (opclass[CLS_R])     state <= EXEC_R;
               else if (opclass[CLS_NORI])  state <= EXEC_I;
               else if (opclass[CLS_LW] || opclass[CLS_SW]) state <= MEMADR;
               else if (opclass[CLS_BLEU])  state <= BRANCH;
               else if (opclass[CLS_JAL])   state <= JAL;
               else                         state <= JR;
            end
            MEMADR: state <= opclass[CLS_SW] ? MEMWR : MEMRD;
            MEMRD:  if (mem_ready) state <= MEMWB;
            MEMWR:  if (mem_ready) state <= FETCH;
            EXEC_R: state <= WB_R;
            EXEC_I: state <= WB_I;
            MEMWB, WB_R, WB_I, BRANCH, JAL, JR: state <= FETCH;
            default: state <= FETCH;
         endcase
      end
   end

   // Output decode from the current state; everything is held low during reset
   always_comb begin
      PCWrite = 1'b0;
      IorD = 1'b0;
      IRWrite = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      RegDst = REGDST_RT;
      MemToReg = MEMTOREG_ALUOUT;
      ALUSrcA = 1'b0;
      ALUSrcB = SRCB_REGB;
      ALUControl = '0;
      PCSrc = PCSRC_ALU;
      Branch = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
      if (!reset) begin
         case (state)
            FETCH: begin
               ALUSrcB = SRCB_FOUR;
               ALUControl = ALU_ADD;
               if (mem_ready) begin
                  IRWrite = 1'b1;
                  PCWrite = 1'b1;
               end
            end
            DECODE: begin
               ALUSrcB = SRCB_IMMSH;
               ALUControl = ALU_ADD;
               illegal_op = !op_valid;
            end
            MEMADR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = SRCB_IMM;
               ALUControl = ALU_ADD;
            end
            MEMRD: IorD = 1'b1;
            MEMWB: begin
               RegWrite = 1'b1;
               MemToReg = MEMTOREG_MDR;
               instr_done = 1'b1;
            end
            MEMWR: begin
               IorD = 1'b1;
               MemWrite = 1'b1;
               instr_done = mem_ready;
            end
            EXEC_R: begin
               ALUSrcA = 1'b1;
               ALUControl = opcode[OP_W-1 -: ALU_W];
            end
            WB_R: begin
               RegWrite = 1'b1;
               RegDst = REGDST_RD;
               instr_done = 1'b1;
            end
            EXEC_I: begin
               ALUSrcA = 1'b1;
               ALUSrcB = SRCB_IMM;
               ALUControl = opcode[OP_W-1 -: ALU_W];
            end
            WB_I: begin
               RegWrite = 1'b1;
               instr_done = 1'b1;
            end
            BRANCH: begin
               ALUSrcA = 1'b1;
               ALUControl = opcode[OP_W-1 -: ALU_W];
               Branch = 1'b1;
               PCSrc = PCSRC_ALUOUT;
               instr_done = 1'b1;
            end
            JAL: begin
               PCWrite = 1'b1;
               PCSrc = PCSRC_JUMP;
               RegWrite = 1'b1;
               RegDst = REGDST_R31;
               MemToReg = MEMTOREG_PC;
               instr_done = 1'b1;
            end
            JR: begin
               PCWrite = 1'b1;
               PCSrc = PCSRC_REGA;
               instr_done = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: directed scenarios plus randomized
// instruction streams with random memory wait states, all compared
// cycle by cycle against a per-instruction step list built from the
// instruction-class rules.
module tb_multicycle_control;

   logic clk = 1'b0;
   logic reset;
   logic [5:0] opcode;
   logic mem_ready;
   logic PCWrite, IorD, IRWrite, MemWrite, RegWrite, ALUSrcA, Branch, instr_done, illegal_op;
   logic [1:0] RegDst, MemToReg, ALUSrcB, PCSrc;
   logic [4:0] ALUControl;

   multicycle_control dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode),
      .mem_ready  (mem_ready),
      .PCWrite    (PCWrite),
      .IorD       (IorD),
      .IRWrite    (IRWrite),
      .MemWrite   (MemWrite),
      .RegWrite   (RegWrite),
      .RegDst     (RegDst),
      .MemToReg   (MemToReg),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ALUControl (ALUControl),
      .PCSrc      (PCSrc),
      .Branch     (Branch),
      .instr_done (instr_done),
      .illegal_op (illegal_op)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic pcwrite, iord, irwrite, memwrite, regwrite;
      logic [1:0] regdst, memtoreg;
      logic alusrca;
      logic [1:0] alusrcb;
      logic [4:0] aluctl;
      logic [1:0] pcsrc;
      logic branch, done, illegal;
   } cw_t;

   localparam logic [4:0] ADD = 5'b11111;
   localparam int K_ILL = 0, K_R = 1, K_NORI = 2, K_LW = 3, K_SW = 4, K_BLEU = 5, K_JAL = 6, K_JR = 7;

   int checks = 0;
   int errors = 0;
   bit timed_out;
   cw_t go_q[$], stall_q[$];
   bit mem_q[$];
   cw_t obs_q[$], exp_q[$];

   function automatic cw_t observe();
      return {PCWrite, IorD, IRWrite, MemWrite, RegWrite, RegDst, MemToReg,
              ALUSrcA, ALUSrcB, ALUControl, PCSrc, Branch, instr_done, illegal_op};
   endfunction

   function automatic int class_of(input logic [5:0] op);
      case (op)
         6'b100000, 6'b100110, 6'b000100, 6'b000000, 6'b000010: return K_R;
         6'b001110: return K_NORI;
         6'b100011: return K_LW;
         6'b101011: return K_SW;
         6'b010000: return K_BLEU;
         6'b000011: return K_JAL;
         6'b001000: return K_JR;
         default:   return K_ILL;
      endcase
   endfunction

   function automatic void push_step(input cw_t g, input cw_t s, input bit m);
      go_q.push_back(g);
      stall_q.push_back(s);
      mem_q.push_back(m);
   endfunction

   // Reference: build the step list of one instruction, then run it on the DUT
   // with mem_ready taken from pat (bit k = cycle k), recording observed and
   // expected control words per cycle.
   task automatic drive_instr(input logic [5:0] op, input logic [31:0] pat, output int cycles);
      cw_t w, s;
      int k, idx;
      logic rdy;
      k = class_of(op);
      go_q.delete(); stall_q.delete(); mem_q.delete();
      w = '0; w.alusrcb = 2'b01; w.aluctl = ADD; s = w;
      w.irwrite = 1; w.pcwrite = 1;
      push_step(w, s, 1);
      w = '0; w.alusrcb = 2'b11; w.aluctl = ADD; w.illegal = (k == K_ILL);
      push_step(w, w, 0);
      case (k)
         K_R, K_NORI: begin
            w = '0; w.alusrca = 1; w.alusrcb = (k == K_NORI) ? 2'b10 : 2'b00; w.aluctl = op[5:1];
            push_step(w, w, 0);
            w = '0; w.regwrite = 1; w.regdst = (k == K_R) ? 2'b01 : 2'b00; w.done = 1;
            push_step(w, w, 0);
         end
         K_LW, K_SW: begin
            w = '0; w.alusrca = 1; w.alusrcb = 2'b10; w.aluctl = ADD;
            push_step(w, w, 0);
            if (k == K_LW) begin
               w = '0; w.iord = 1;
               push_step(w, w, 1);
               w = '0; w.regwrite = 1; w.memtoreg = 2'b01; w.done = 1;
               push_step(w, w, 0);
            end else begin
               s = '0; s.iord = 1; s.memwrite = 1; w = s; w.done = 1;
               push_step(w, s, 1);
            end
         end
         K_BLEU: begin
            w = '0; w.alusrca = 1; w.aluctl = op[5:1]; w.branch = 1; w.pcsrc = 2'b01; w.done = 1;
            push_step(w, w, 0);
         end
         K_JAL: begin
            w = '0; w.pcwrite = 1; w.pcsrc = 2'b10; w.regwrite = 1; w.regdst = 2'b10;
            w.memtoreg = 2'b10; w.done = 1;
            push_step(w, w, 0);
         end
         K_JR: begin
            w = '0; w.pcwrite = 1; w.pcsrc = 2'b11; w.done = 1;
            push_step(w, w, 0);
         end
         default: ;
      endcase
      obs_q.delete(); exp_q.delete();
      idx = 0; cycles = 0;
      while (idx < go_q.size() && cycles < 40) begin
         rdy = (cycles >= 31) ? 1'b1 : pat[cycles];
         mem_ready = rdy;
         opcode = (idx == 0) ? 6'($urandom) : op;
         @(negedge clk);
         obs_q.push_back(observe());
         exp_q.push_back((mem_q[idx] && !rdy) ? stall_q[idx] : go_q[idx]);
         if (!mem_q[idx] || rdy) idx++;
         cycles++;
         @(posedge clk); #1;
      end
      timed_out = (idx < go_q.size());
   endtask

   // Reset forces every output low whatever mem_ready does, then FETCH appears
   task automatic test_reset();
      cw_t fetch_stall;
      reset = 1; mem_ready = 1; opcode = 6'b100011;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         mem_ready = i[0];
         @(negedge clk);
         checks++;
         if (observe() !== cw_t'(0)) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %h want 0", observe());
         end
         @(posedge clk); #1;
      end
      reset = 0; mem_ready = 0;
      fetch_stall = '0; fetch_stall.alusrcb = 2'b01; fetch_stall.aluctl = ADD;
      @(negedge clk);
      checks++;
      if (observe() !== fetch_stall) begin
         errors++;
         $display("[TB] FAIL reset_fetch got %h want %h", observe(), fetch_stall);
      end
      @(posedge clk); #1;
   endtask

   // R-class andr with no wait states
   task automatic test_r_type();
      int cyc;
      drive_instr(6'b100000, 32'hFFFF_FFFF, cyc);
      foreach (obs_q[i]) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("[TB] FAIL andr_cycle%0d got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      checks++;
      if (timed_out || cyc != 4 || obs_q[2].aluctl !== 5'b10000 || obs_q[3].regdst !== 2'b01) begin
         errors++;
         $display("[TB] FAIL andr_latency got %0d cycles want 4 (aluctl %b)", cyc, obs_q[2].aluctl);
      end
   endtask

   // Load with two wait states in the read phase
   task automatic test_lw_stall();
      int cyc;
      drive_instr(6'b100011, 32'h0000_0067, cyc);
      foreach (obs_q[i]) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("[TB] FAIL lw_cycle%0d got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      checks++;
      if (timed_out || cyc != 7 || obs_q[6].done !== 1'b1 || obs_q[6].memtoreg !== 2'b01) begin
         errors++;
         $display("[TB] FAIL lw_latency got %0d cycles want 7", cyc);
      end
   endtask

   // Store with one wait state: write strobe held exactly two cycles
   task automatic test_sw_stall();
      int cyc, nwr, nreg;
      drive_instr(6'b101011, 32'h0000_0017, cyc);
      nwr = 0; nreg = 0;
      foreach (obs_q[i]) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("[TB] FAIL sw_cycle%0d got %h want %h", i, obs_q[i], exp_q[i]);
         end
         if (obs_q[i].memwrite === 1'b1) nwr++;
         if (obs_q[i].regwrite === 1'b1) nreg++;
      end
      checks++;
      if (timed_out || cyc != 5 || nwr != 2 || nreg != 0) begin
         errors++;
         $display("[TB] FAIL sw_strobes got cyc=%0d wr=%0d reg=%0d want 5/2/0", cyc, nwr, nreg);
      end
   endtask

   // jal followed directly by jr
   task automatic test_jal_jr();
      int cyc;
      logic [5:0] ops [2];
      ops[0] = 6'b000011; ops[1] = 6'b001000;
      for (int j = 0; j < 2; j++) begin
         drive_instr(ops[j], 32'hFFFF_FFFF, cyc);
         foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
               errors++;
               $display("[TB] FAIL jump%0d_cycle%0d got %h want %h", j, i, obs_q[i], exp_q[i]);
            end
         end
         checks++;
         if (timed_out || cyc != 3 || obs_q[2].pcsrc !== (j == 0 ? 2'b10 : 2'b11)) begin
            errors++;
            $display("[TB] FAIL jump%0d_latency got %0d cycles pcsrc %b want 3", j, cyc, obs_q[2].pcsrc);
         end
      end
   endtask

   // Unknown opcode returns from DECODE with a pulse; bleu takes the branch path
   task automatic test_illegal_branch();
      int cyc, nstrobe;
      drive_instr(6'b111111, 32'hFFFF_FFFF, cyc);
      nstrobe = 0;
      foreach (obs_q[i]) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("[TB] FAIL illegal_cycle%0d got %h want %h", i, obs_q[i], exp_q[i]);
         end
         if (obs_q[i].memwrite === 1'b1 || obs_q[i].regwrite === 1'b1) nstrobe++;
      end
      checks++;
      if (timed_out || cyc != 2 || obs_q[1].illegal !== 1'b1 || nstrobe != 0) begin
         errors++;
         $display("[TB] FAIL illegal_flow got %0d cycles strobes %0d want 2/0", cyc, nstrobe);
      end
      drive_instr(6'b010000, 32'hFFFF_FFFF, cyc);
      foreach (obs_q[i]) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("[TB] FAIL bleu_cycle%0d got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      checks++;
      if (timed_out || cyc != 3 || obs_q[2].branch !== 1'b1 || obs_q[2].pcsrc !== 2'b01) begin
         errors++;
         $display("[TB] FAIL bleu_latency got %0d cycles want 3", cyc);
      end
   endtask

   // Reset held three cycles in the middle of a store write
   task automatic test_reset_mid_store();
      cw_t fetch_stall;
      int cyc;
      opcode = 6'b101011; mem_ready = 1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      mem_ready = 0;
      @(negedge clk);
      checks++;
      if (MemWrite !== 1'b1 || IorD !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midstore_enter got MemWrite=%b IorD=%b want 1/1", MemWrite, IorD);
      end
      @(posedge clk); #1;
      reset = 1; mem_ready = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (observe() !== cw_t'(0)) begin
            errors++;
            $display("[TB] FAIL midstore_reset%0d got %h want 0", i, observe());
         end
         @(posedge clk); #1;
      end
      reset = 0; mem_ready = 0;
      fetch_stall = '0; fetch_stall.alusrcb = 2'b01; fetch_stall.aluctl = ADD;
      @(negedge clk);
      checks++;
      if (observe() !== fetch_stall) begin
         errors++;
         $display("[TB] FAIL midstore_fetch got %h want %h", observe(), fetch_stall);
      end
      @(posedge clk); #1;
      drive_instr(6'b001110, 32'hFFFF_FFFF, cyc);
      foreach (obs_q[i]) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("[TB] FAIL nori_cycle%0d got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   // Random instruction stream with random wait states
   task automatic test_random();
      int cyc, sel;
      logic [5:0] op;
      logic [5:0] ops [12];
      ops = '{6'b100000, 6'b100110, 6'b000100, 6'b000000, 6'b000010, 6'b001110,
              6'b100011, 6'b101011, 6'b010000, 6'b000011, 6'b001000, 6'b111101};
      for (int n = 0; n < 60; n++) begin
         sel = $urandom_range(0, 12);
         op = (sel == 12) ? 6'($urandom) : ops[sel];
         drive_instr(op, $urandom | $urandom, cyc);
         foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
               errors++;
               $display("[TB] FAIL rand%0d_op%b_cycle%0d got %h want %h", n, op, i, obs_q[i], exp_q[i]);
            end
         end
         checks++;
         if (timed_out) begin
            errors++;
            $display("[TB] FAIL rand%0d_timeout got %0d cycles want completion", n, cyc);
         end
      end
   endtask

   initial begin
      reset = 1; mem_ready = 0; opcode = '0;
      test_reset();
      test_r_type();
      test_lw_stall();
      test_sw_stall();
      test_jal_jr();
      test_illegal_branch();
      test_reset_mid_store();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
